// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, parity modes and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // data_xor is the XOR-reduction of the data word, par_bit the received parity bit
    function automatic logic parity_error(input int mode, input logic data_xor, input logic par_bit);
        logic ones_odd;
        ones_odd = data_xor ^ par_bit;
        case (mode)
            PAR_ODD:  parity_error = ~ones_odd;
            PAR_EVEN: parity_error = ones_odd;
            default:  parity_error = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with error flags and valid/ready output
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    logic                 rx_s;
    uart_state_e          state_q,   state_d;
    logic [CW-1:0]        cnt_q,     cnt_d;
    logic [BW-1:0]        idx_q,     idx_d;
    logic [DATA_BITS-1:0] shreg_q,   shreg_d;
    logic                 perr_q,    perr_d;
    logic                 ferr_q,    ferr_d;
    logic                 deliver_q, deliver_d;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (rx_pin),
        .q_o     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            deliver_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            deliver_q <= deliver_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        deliver_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Flags clear only when a new frame starts, so a pending delivery still sees them
                if (!rx_s) begin
                    state_d = ST_START;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end

            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (idx_q == BIT_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    perr_d  = parity_error(PARITY, ^shreg_q, rx_s);
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end
                    if (idx_q == STOP_LAST) begin
                        idx_d     = '0;
                        deliver_d = 1'b1;
                        state_d   = rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // A held word is never overwritten: a new frame either loads into a free/accepted slot or is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= deliver_q & rx_valid_q & ~rx_ready;
            if (deliver_q && (!rx_valid_q || rx_ready)) begin
                rx_data_q    <= shreg_q;
                parity_err_q <= perr_q;
                frame_err_q  <= ferr_q;
                rx_valid_q   <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
